// File: rtl/wb_dcache_write_ctrl.sv
// Writeback store sequencer: buffers one store and splits it into one or
// two 8-byte-aligned dcache beats with lane-aligned data and byte enables.
// Ports:
//   CLK, CLR (async, active-high)
//   req_*  : store from the writeback stage; req_ready grants it
//   dc_*   : beat to the dcache, retired when dc_ready is high
//   ld_addr/ld_conflict : load vs. pending-store block hazard
//   busy, wr_count : status and completed-store counter
module wb_dcache_write_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             req_v,
   input  logic [31:0]      req_addr,
   input  logic [1:0]       req_size,
   input  logic [63:0]      req_data,
   output logic             req_ready,
   output logic             dc_wr_en,
   output logic [31:0]      dc_addr,
   output logic [63:0]      dc_data,
   output logic [7:0]       dc_byte_en,
   input  logic             dc_ready,
   input  logic [31:0]      ld_addr,
   output logic             ld_conflict,
   output logic             busy,
   output logic [CNT_W-1:0] wr_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [28:0]      blk_q, blk_d;
   logic [63:0]      d0_q, d0_d;
   logic [63:0]      d1_q, d1_d;
   logic [7:0]       be0_q, be0_d;
   logic [7:0]       be1_q, be1_d;
   logic             split_q, split_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [7:0]   base;
   logic [63:0]  data_m;
   logic [15:0]  mask16;
   logic [127:0] dshift;
   logic [28:0]  blk1;
   logic [28:0]  cur_blk;
   logic         fin;
   logic         done;
   logic         ld_unused;

   assign ld_unused = ^ld_addr[2:0];

   // Byte-enable base pattern and data with unused upper bytes cleared.
   always_comb begin
      base = 8'h01;
      unique case (req_size)
         2'd0: base = 8'h01;
         2'd1: base = 8'h03;
         2'd2: base = 8'h0F;
         2'd3: base = 8'hFF;
         default: base = 8'h01;
      endcase
      data_m = '0;
      for (int i = 0; i < 8; i++) begin
         data_m[8*i +: 8] = req_data[8*i +: 8] & {8{base[i]}};
      end
      mask16 = {8'h00, base} << req_addr[2:0];
      dshift = {64'h0, data_m} << {req_addr[2:0], 3'b000};
   end

   // Second block wraps naturally in 29 bits (0xFFFFFFF8 -> 0x0).
   assign blk1 = blk_q + 29'd1;

   assign busy     = (state_q != IDLE);
   assign dc_wr_en = busy;
   assign wr_count = cnt_q;

   // Final beat retiring frees the buffer in the same cycle.
   assign fin  = ((state_q == BEAT0) && !split_q) || (state_q == BEAT1);
   assign done = fin && dc_ready;
   assign req_ready = (state_q == IDLE) || done;

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      be0_d   = be0_q;
      be1_d   = be1_q;
      split_d = split_q;
      cnt_d   = cnt_q;
      if (done) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = IDLE;
      end else if ((state_q == BEAT0) && dc_ready) begin
         state_d = BEAT1;
      end
      if (req_v && req_ready) begin
         state_d = BEAT0;
         blk_d   = req_addr[31:3];
         d0_d    = dshift[63:0];
         d1_d    = dshift[127:64];
         be0_d   = mask16[7:0];
         be1_d   = mask16[15:8];
         split_d = (mask16[15:8] != 8'h00);
      end
   end

   always_comb begin
      cur_blk    = '0;
      dc_data    = '0;
      dc_byte_en = '0;
      unique case (state_q)
         IDLE: begin
         end
         BEAT0: begin
            cur_blk    = blk_q;
            dc_data    = d0_q;
            dc_byte_en = be0_q;
         end
         BEAT1: begin
            cur_blk    = blk1;
            dc_data    = d1_q;
            dc_byte_en = be1_q;
         end
         default: begin
         end
      endcase
      dc_addr = {cur_blk, 3'b000};
   end

   // A split store still in BEAT0 also owns its second block.
   assign ld_conflict = busy &&
      ((ld_addr[31:3] == cur_blk) ||
       ((state_q == BEAT0) && split_q && (ld_addr[31:3] == blk1)));

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q <= IDLE;
         blk_q   <= '0;
         d0_q    <= '0;
         d1_q    <= '0;
         be0_q   <= '0;
         be1_q   <= '0;
         split_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         be0_q   <= be0_d;
         be1_q   <= be1_d;
         split_q <= split_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
